// File: rtl/bias_seq_ctrl_if.sv
// Stream bundle around bias_seq_ctrl.
//   s_*  : 128-bit bias words from the layer-config DMA into the controller
//   m_*  : one output group (8 x 32-bit biases) from the controller downstream
// Modports:
//   master : the controller's view (sinks s_*, sources m_*)
//   slave  : the surrounding environment's view (DMA source + downstream sink)
interface bias_seq_ctrl_if #(
    parameter int GROUP_W = 7
);
    logic [127:0]        s_data;
    logic                s_valid;
    logic                s_ready;
    logic [7:0][31:0]    m_bias;
    logic [GROUP_W-1:0]  m_group;
    logic                m_last;
    logic                m_valid;
    logic                m_ready;

    modport master (
        input  s_data, s_valid, m_ready,
        output s_ready, m_bias, m_group, m_last, m_valid
    );

    modport slave (
        output s_data, s_valid, m_ready,
        input  s_ready, m_bias, m_group, m_last, m_valid
    );
endinterface

// File: rtl/bias_seq_ctrl.sv
// bias_seq_ctrl: loads 2*N 128-bit bias words into bias_store, then replays
// groups 0..N-1 for P passes, presenting each group on the m_* stream.
// Ports:
//   clk, rst                  clock, async active-high reset
//   cfg_start/num_groups/passes  layer start pulse and its N, P (IDLE only)
//   cfg_abort                 return to IDLE from any state, no done pulse
//   bus (master)              s_* word stream in, m_* group stream out
//   store_clr                 one-cycle rewind of the store write pointer
//   wr_en, wr_data            store write port
//   rd_en, rd_group           store read request
//   bias_in, rd_valid_in      store read response
//   busy, done                state != IDLE, completion pulse
module bias_seq_ctrl #(
    parameter int MAX_DEPTH = 256,
    parameter int GROUP_W   = $clog2(MAX_DEPTH) - 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cfg_start,
    input  logic [GROUP_W:0]    cfg_num_groups,
    input  logic [15:0]         cfg_passes,
    input  logic                cfg_abort,
    bias_seq_ctrl_if.master     bus,
    output logic                store_clr,
    output logic                wr_en,
    output logic [127:0]        wr_data,
    output logic                rd_en,
    output logic [GROUP_W-1:0]  rd_group,
    input  logic [7:0][31:0]    bias_in,
    input  logic                rd_valid_in,
    output logic                busy,
    output logic                done
);
    typedef enum logic [2:0] {IDLE, LOAD, ISSUE, WAIT, PRESENT, DONE} state_t;

    localparam logic [GROUP_W:0]   N_ONE = 1;
    localparam logic [GROUP_W+1:0] W_ONE = 1;
    localparam logic [GROUP_W-1:0] G_ONE = 1;
    localparam logic [15:0]        P_ONE = 1;

    state_t               state_q, state_d;
    logic [GROUP_W:0]     n_q, n_d;
    logic [15:0]          np_q, np_d;
    logic [GROUP_W+1:0]   wcnt_q, wcnt_d;
    logic [GROUP_W-1:0]   g_q, g_d;
    logic [15:0]          p_q, p_d;
    logic                 store_clr_q, store_clr_d;
    logic                 rd_en_q, rd_en_d;
    logic [GROUP_W-1:0]   rd_group_q, rd_group_d;
    logic [7:0][31:0]     m_bias_q, m_bias_d;
    logic [GROUP_W-1:0]   m_group_q, m_group_d;
    logic                 m_last_q, m_last_d;
    logic                 m_valid_q, m_valid_d;
    logic                 done_q, done_d;

    logic [GROUP_W:0]     n_m1;
    logic                 g_last, p_last, w_last, accept, hs;

    assign n_m1   = n_q - N_ONE;
    assign g_last = ({1'b0, g_q} == n_m1);
    assign p_last = (p_q == (np_q - P_ONE));
    assign w_last = (wcnt_q == ({n_q, 1'b0} - W_ONE));

    // No accept while store_clr is high: the clear rewinds the store's write
    // pointer that same cycle and would swallow word 0.
    assign bus.s_ready = (state_q == LOAD) && !store_clr_q && !cfg_abort;
    assign accept      = bus.s_valid && bus.s_ready;
    assign wr_en       = accept;
    assign wr_data     = bus.s_ready ? bus.s_data : '0;

    // Registered strobes are masked combinationally so an abort takes
    // effect in the cycle it is asserted.
    assign rd_en       = rd_en_q && !cfg_abort;
    assign rd_group    = rd_group_q;
    assign bus.m_valid = m_valid_q && !cfg_abort;
    assign bus.m_bias  = m_bias_q;
    assign bus.m_group = m_group_q;
    assign bus.m_last  = m_last_q;
    assign hs          = bus.m_valid && bus.m_ready;

    assign store_clr   = store_clr_q;
    assign busy        = (state_q != IDLE);
    assign done        = done_q;

    always_comb begin
        state_d     = state_q;
        n_d         = n_q;
        np_d        = np_q;
        wcnt_d      = wcnt_q;
        g_d         = g_q;
        p_d         = p_q;
        store_clr_d = 1'b0;
        rd_en_d     = 1'b0;
        rd_group_d  = rd_group_q;
        m_bias_d    = m_bias_q;
        m_group_d   = m_group_q;
        m_last_d    = m_last_q;
        m_valid_d   = m_valid_q;
        done_d      = 1'b0;
        if (cfg_abort) begin
            // In IDLE this also swallows a coincident cfg_start.
            if (state_q != IDLE) begin
                state_d   = IDLE;
                m_valid_d = 1'b0;
            end
        end else begin
            case (state_q)
                IDLE: if (cfg_start) begin
                    n_d    = cfg_num_groups;
                    np_d   = cfg_passes;
                    wcnt_d = '0;
                    g_d    = '0;
                    p_d    = '0;
                    if (cfg_num_groups == '0 || cfg_passes == '0) begin
                        state_d = DONE;
                    end else begin
                        state_d     = LOAD;
                        store_clr_d = 1'b1;
                    end
                end
                LOAD: if (accept) begin
                    wcnt_d = wcnt_q + W_ONE;
                    if (w_last) begin
                        state_d    = ISSUE;
                        g_d        = '0;
                        p_d        = '0;
                        rd_en_d    = 1'b1;
                        rd_group_d = '0;
                    end
                end
                ISSUE: state_d = WAIT;
                WAIT: if (rd_valid_in) begin
                    m_bias_d  = bias_in;
                    m_group_d = g_q;
                    m_last_d  = g_last;
                    m_valid_d = 1'b1;
                    state_d   = PRESENT;
                end
                PRESENT: if (hs) begin
                    m_valid_d = 1'b0;
                    if (!g_last) begin
                        g_d        = g_q + G_ONE;
                        rd_group_d = g_q + G_ONE;
                        rd_en_d    = 1'b1;
                        state_d    = ISSUE;
                    end else if (!p_last) begin
                        g_d        = '0;
                        p_d        = p_q + P_ONE;
                        rd_group_d = '0;
                        rd_en_d    = 1'b1;
                        state_d    = ISSUE;
                    end else begin
                        state_d = DONE;
                    end
                end
                DONE: begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            n_q         <= '0;
            np_q        <= '0;
            wcnt_q      <= '0;
            g_q         <= '0;
            p_q         <= '0;
            store_clr_q <= 1'b0;
            rd_en_q     <= 1'b0;
            rd_group_q  <= '0;
            m_bias_q    <= '0;
            m_group_q   <= '0;
            m_last_q    <= 1'b0;
            m_valid_q   <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            n_q         <= n_d;
            np_q        <= np_d;
            wcnt_q      <= wcnt_d;
            g_q         <= g_d;
            p_q         <= p_d;
            store_clr_q <= store_clr_d;
            rd_en_q     <= rd_en_d;
            rd_group_q  <= rd_group_d;
            m_bias_q    <= m_bias_d;
            m_group_q   <= m_group_d;
            m_last_q    <= m_last_d;
            m_valid_q   <= m_valid_d;
            done_q      <= done_d;
        end
    end
endmodule
